fifo_sync_fwft: RTL and testbench

Single-clock, first-word-fall-through FIFO controller with its own simple dual-port storage. It sits between a producing stage and the finder's consuming logic. It owns the write/read pointers, occupancy and flags, and a one-entry prefetch register. The head word is always presented on `rdata` with `rdata_valid` and does not have to be requested first.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_sdp_mem.sv | 39 +++
 rtl/fifo_sync_fwft.sv | 134 +++++++++++++
 tb/tb_fifo_sync_fwft.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous first-word-fall-through FIFO.
package fifo_pkg;

    // Width of the count/occupancy registers: one bit wider than the address.
    function automatic int unsigned cnt_w(input int unsigned asize);
        return asize + 32'd1;
    endfunction

    // Default almost_full threshold: four words short of full, never below 1.
    function automatic int unsigned af_level_default(input int unsigned asize);
        int unsigned depth;
        depth = 32'd1 << asize;
        return (depth > 32'd4) ? (depth - 32'd4) : 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sdp_mem.sv
// Single-clock simple dual-port storage; the registered read port doubles as
// the FIFO prefetch register.
module fifo_sdp_mem #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wea,
    input  logic [ASIZE-1:0] addra,
    input  logic [DSIZE-1:0] dina,
    input  logic             enb,
    input  logic [ASIZE-1:0] addrb,
    output logic [DSIZE-1:0] doutb
);

    localparam int unsigned DEPTH = 32'd1 << ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [DSIZE-1:0] r_doutb;

    // Storage array is deliberately left uninitialised on reset.
    always_ff @(posedge clk) begin
        if (wea) begin
            r_mem[addra] <= dina;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_doutb <= '0;
        end else if (enb) begin
            r_doutb <= r_mem[addrb];
        end
    end

    assign doutb = r_doutb;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FWFT FIFO controller: pointers, occupancy, flags and prefetch.
// Optional sticky overflow/underflow ports are built with FIFO_ERR_FLAGS_EN.
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned ASIZE    = 10,
    parameter int unsigned AF_LEVEL = af_level_default(ASIZE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DSIZE-1:0]        wdata,
    output logic                    full,
    output logic                    almost_full,
    input  logic                    rd_en,
    output logic [DSIZE-1:0]        rdata,
    output logic                    rdata_valid,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic [cnt_w(ASIZE)-1:0] count
);

    localparam int unsigned CW    = cnt_w(ASIZE);
    localparam int unsigned DEPTH = 32'd1 << ASIZE;

    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_rdata_valid;
    logic             r_full;
    logic             r_almost_full;

    logic             w_push;
    logic             w_pop;
    logic             w_pf;
    logic [ASIZE-1:0] w_wptr_nxt;
    logic [ASIZE-1:0] w_rptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_ram_cnt_nxt;
    logic             w_valid_nxt;
    logic             w_full_nxt;
    logic             w_af_nxt;

    // ram_cnt only counts pushes from earlier edges, so a prefetch can never
    // target the address being written in the same cycle.
    always_comb begin
        w_push        = wr_en && !r_full && !rst;
        w_pop         = rd_en && r_rdata_valid && !rst;
        w_pf          = (r_ram_cnt != '0) && (!r_rdata_valid || w_pop) && !rst;
        w_wptr_nxt    = r_wptr;
        w_rptr_nxt    = r_rptr;
        w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
        w_ram_cnt_nxt = r_ram_cnt + CW'(w_push) - CW'(w_pf);
        w_valid_nxt   = r_rdata_valid;
        if (w_push) begin
            w_wptr_nxt = r_wptr + ASIZE'(1);
        end
        if (w_pf) begin
            w_rptr_nxt  = r_rptr + ASIZE'(1);
            w_valid_nxt = 1'b1;
        end else if (w_pop) begin
            w_valid_nxt = 1'b0;
        end
        w_full_nxt = (w_count_nxt == CW'(DEPTH));
        w_af_nxt   = (w_count_nxt >= CW'(AF_LEVEL));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_ram_cnt     <= '0;
            r_rdata_valid <= 1'b0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_ram_cnt     <= w_ram_cnt_nxt;
            r_rdata_valid <= w_valid_nxt;
            r_full        <= w_full_nxt;
            r_almost_full <= w_af_nxt;
        end
    end

    fifo_sdp_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .wea   (w_push),
        .addra (r_wptr),
        .dina  (wdata),
        .enb   (w_pf),
        .addrb (r_rptr),
        .doutb (rdata)
    );

`ifdef FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky request-while-unavailable flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && !r_rdata_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign rdata_valid = r_rdata_valid;
    assign count       = r_count;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Scoreboard bench for fifo_sync_fwft at ASIZE=3 (8 words, almost_full at 4).
`timescale 1ns/1ps
module tb_fifo_sync_fwft;

    localparam int unsigned DSIZE = 8;
    localparam int unsigned ASIZE = 3;
    localparam int          DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [DSIZE-1:0] wdata;
    logic             full;
    logic             almost_full;
    logic             rd_en;
    logic [DSIZE-1:0] rdata;
    logic             rdata_valid;
    logic [ASIZE:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Bench reference state, as it stands after the most recent edge.
    logic [DSIZE-1:0] exp_q[$];
    int               m_count = 0;
    int               m_ram   = 0;
    logic             m_valid = 1'b0;

    fifo_sync_fwft #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wdata       (wdata),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted pop must present the oldest expected word.
    always @(negedge clk) begin
        logic [DSIZE-1:0] exp_w;
        if (!rst && rd_en && m_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_pop: pop with empty scoreboard, rdata=%02h", rdata);
            end else begin
                exp_w = exp_q.pop_front();
                if (rdata !== exp_w || rdata_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL sb_pop: got rdata=%02h valid=%b, expected %02h valid=1",
                             rdata, rdata_valid, exp_w);
                end
            end
        end
    end

    // One clock of stimulus; the reference model advances at the edge.
    task automatic cycle(input logic we, input logic [DSIZE-1:0] wd, input logic re);
        logic acc_push;
        logic acc_pop;
        logic pf;
        wr_en    = we;
        wdata    = wd;
        rd_en    = re;
        acc_push = we && (m_count != DEPTH);
        acc_pop  = re && m_valid;
        pf       = (m_ram != 0) && (!m_valid || acc_pop);
        if (acc_push) exp_q.push_back(wd);
        @(posedge clk);
        m_count = m_count + int'(acc_push) - int'(acc_pop);
        m_ram   = m_ram + int'(acc_push) - int'(pf);
        if (pf) m_valid = 1'b1;
        else if (acc_pop) m_valid = 1'b0;
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic apply_reset(input logic we, input logic re);
        rst   = 1'b1;
        wr_en = we;
        wdata = 8'hEE;
        rd_en = re;
        @(posedge clk);
        exp_q.delete();
        m_count = 0;
        m_ram   = 0;
        m_valid = 1'b0;
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0, 1'b0);
        n_checks++;
        if (count !== 4'd0 || full !== 1'b0 || almost_full !== 1'b0 ||
            rdata_valid !== 1'b0 || rdata !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state: count=%0d full=%b af=%b valid=%b rdata=%02h, expected 0 0 0 0 00",
                     count, full, almost_full, rdata_valid, rdata);
        end
    endtask

    task automatic test_single_push();
        cycle(1'b1, 8'hA5, 1'b0);
        n_checks++;
        if (rdata_valid !== 1'b0 || count !== 4'd1) begin
            n_errors++;
            $display("FAIL single_e: valid=%b count=%0d, expected valid=0 count=1", rdata_valid, count);
        end
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (rdata_valid !== 1'b1 || rdata !== 8'hA5 || count !== 4'd1) begin
            n_errors++;
            $display("FAIL single_e1: valid=%b rdata=%02h count=%0d, expected 1 A5 1",
                     rdata_valid, rdata, count);
        end
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (rdata_valid !== 1'b0 || count !== 4'd0) begin
            n_errors++;
            $display("FAIL single_pop: valid=%b count=%0d, expected 0 0", rdata_valid, count);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DSIZE'(i), 1'b0);
            if (i == 2 || i == 3) begin
                n_checks++;
                if (almost_full !== (i == 3)) begin
                    n_errors++;
                    $display("FAIL af_boundary: count=%0d af=%b, expected %b", count, almost_full, (i == 3));
                end
            end
        end
        n_checks++;
        if (full !== 1'b1 || count !== 4'd8 || almost_full !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_full: full=%b count=%0d af=%b, expected 1 8 1", full, count, almost_full);
        end
        cycle(1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL push_when_full: count=%0d full=%b, expected 8 1", count, full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_checks++;
        if (overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_flag: overflow=%b, expected 1", overflow);
        end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            if (i < DEPTH - 1) begin
                n_checks++;
                if (rdata_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL drain_rate: pop %0d valid=%b, expected 1", i, rdata_valid);
                end
            end
        end
        n_checks++;
        if (rdata_valid !== 1'b0 || count !== 4'd0 || full !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_end: valid=%b count=%0d full=%b left=%0d, expected 0 0 0 0",
                     rdata_valid, count, full, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + DSIZE'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'h50 + DSIZE'(i), 1'b1);
            n_checks++;
            if (count !== 4'd4 || rdata_valid !== 1'b1 || almost_full !== 1'b1) begin
                n_errors++;
                $display("FAIL steady_state: cycle %0d count=%0d valid=%b af=%b, expected 4 1 1",
                         i, count, rdata_valid, almost_full);
            end
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd0 || rdata_valid !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL steady_drain: count=%0d valid=%b left=%0d, expected 0 0 0",
                     count, rdata_valid, exp_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h60 + DSIZE'(i), 1'b0);
        cycle(1'b1, 8'h99, 1'b1);
        n_checks++;
        if (count !== 4'd7 || full !== 1'b0 || rdata_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL full_push_pop: count=%0d full=%b valid=%b, expected 7 0 1",
                     count, full, rdata_valid);
        end
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL full_drain: count=%0d left=%0d, expected 0 0", count, exp_q.size());
        end
    endtask

    task automatic test_underflow();
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd0 || rdata_valid !== 1'b0 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_pop: count=%0d valid=%b full=%b, expected 0 0 0",
                     count, rdata_valid, full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_checks++;
        if (underflow !== 1'b1) begin
            n_errors++;
            $display("FAIL underflow_flag: underflow=%b, expected 1", underflow);
        end
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h70 + DSIZE'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        apply_reset(1'b1, 1'b1);
        n_checks++;
        if (count !== 4'd0 || rdata_valid !== 1'b0 || rdata !== 8'h00 ||
            full !== 1'b0 || almost_full !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: count=%0d valid=%b rdata=%02h full=%b af=%b, expected 0 0 00 0 0",
                     count, rdata_valid, rdata, full, almost_full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        n_checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_flags: overflow=%b underflow=%b, expected 0 0", overflow, underflow);
        end
`endif
        cycle(1'b1, 8'h3C, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (rdata_valid !== 1'b1 || rdata !== 8'h3C || count !== 4'd1) begin
            n_errors++;
            $display("FAIL post_reset_push: valid=%b rdata=%02h count=%0d, expected 1 3C 1",
                     rdata_valid, rdata, count);
        end
        cycle(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (count !== 4'd0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL post_reset_pop: count=%0d left=%0d, expected 0 0", count, exp_q.size());
        end
    endtask

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        wdata = '0;
        rd_en = 1'b0;
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_full_push_pop();
        test_underflow();
        test_mid_reset();
        cycle(1'b0, 8'h00, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
